// File: rtl/modexp_sequencer.sv
// modexp_sequencer
//   Control sequencer for a left-to-right (MSB first) Montgomery modular
//   exponentiation. It launches one streaming datapath pass at a time
//   (INIT, then SQUARE per exponent bit, MULT for every 1 bit, then FROMMONT)
//   and fetches exponent blocks from an external store as the bit index
//   crosses a block boundary.
//
// Ports
//   clk_in          single clock
//   rst_in          asynchronous, active-high reset
//   start_in        one-cycle request to begin an exponentiation
//   exp_addr_out    exponent block index presented to the exponent store
//   exp_block_in    exponent block data, valid one cycle after exp_addr_out
//   pass_start_out  one-cycle pulse launching one datapath pass
//   pass_op_out     pass opcode: 00 INIT, 01 SQUARE, 10 MULT, 11 FROMMONT
//   pass_done_in    one-cycle pulse: the current pass has drained
//   busy_out        high from the cycle after an accepted start until done_out
//   done_out        one-cycle pulse: exponentiation complete
module modexp_sequencer #(
  parameter int REGISTER_SIZE = 32,
  parameter int EXP_BITS      = 2048
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          start_in,
  output logic [$clog2(EXP_BITS/REGISTER_SIZE)-1:0]     exp_addr_out,
  input  logic [REGISTER_SIZE-1:0]                      exp_block_in,
  output logic                                          pass_start_out,
  output logic [1:0]                                    pass_op_out,
  input  logic                                          pass_done_in,
  output logic                                          busy_out,
  output logic                                          done_out
);

  localparam int NBLK = EXP_BITS / REGISTER_SIZE;
  localparam int AW   = $clog2(NBLK);
  localparam int BW   = $clog2(EXP_BITS);
  localparam int PW   = $clog2(REGISTER_SIZE);

  localparam logic [1:0] OP_INIT     = 2'b00;
  localparam logic [1:0] OP_SQUARE   = 2'b01;
  localparam logic [1:0] OP_MULT     = 2'b10;
  localparam logic [1:0] OP_FROMMONT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [BW-1:0]            bit_q, bit_d;     // current exponent bit index
  logic [PW-1:0]            pos_q, pos_d;     // bit position inside the latched block
  logic [AW-1:0]            addr_q, addr_d;   // block index (= bit index / REGISTER_SIZE)
  logic [1:0]               op_q, op_d;
  logic                     busy_q, busy_d;
  logic [REGISTER_SIZE-1:0] blk_q, blk_d;     // latched exponent block
  logic                     advance;          // move on to the next lower bit

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    pos_d   = pos_q;
    addr_d  = addr_q;
    op_d    = op_q;
    busy_d  = busy_q;
    blk_d   = blk_q;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          bit_d   = BW'(EXP_BITS - 1);
          pos_d   = PW'(REGISTER_SIZE - 1);
          op_d    = OP_INIT;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end

      // exp_addr_out was loaded on entry, so the store answers in LATCH
      S_FETCH: state_d = S_LATCH;

      S_LATCH: begin
        blk_d   = exp_block_in;
        op_d    = OP_SQUARE;
        state_d = S_ISSUE;
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        if (pass_done_in) begin
          case (op_q)
            OP_INIT: begin
              // the top bit always sits at the top of the last block
              addr_d  = AW'(NBLK - 1);
              state_d = S_FETCH;
            end
            OP_SQUARE: begin
              if (blk_q[pos_q]) begin
                op_d    = OP_MULT;
                state_d = S_ISSUE;
              end else begin
                advance = 1'b1;
              end
            end
            OP_MULT: advance = 1'b1;
            default: begin
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          endcase
        end

        if (advance) begin
          if (bit_q == '0) begin
            // no wrap below bit 0: finish with the conversion pass instead
            op_d    = OP_FROMMONT;
            state_d = S_ISSUE;
          end else begin
            bit_d = bit_q - BW'(1);
            if (pos_q == '0) begin
              pos_d   = PW'(REGISTER_SIZE - 1);
              addr_d  = addr_q - AW'(1);
              state_d = S_FETCH;
            end else begin
              pos_d   = pos_q - PW'(1);
              op_d    = OP_SQUARE;
              state_d = S_ISSUE;
            end
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      pos_q   <= '0;
      addr_q  <= '0;
      op_q    <= OP_INIT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      pos_q   <= pos_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
    end
  end

  // Block data is only consumed after a LATCH, so it needs no reset
  always_ff @(posedge clk_in) begin
    blk_q <= blk_d;
  end

  assign exp_addr_out   = addr_q;
  assign pass_start_out = (state_q == S_ISSUE);
  assign pass_op_out    = op_q;
  assign busy_out       = busy_q;
  assign done_out       = (state_q == S_DONE);

endmodule

// File: tb/tb_modexp_sequencer.sv
module tb_modexp_sequencer;

  localparam int RS = 32;
  localparam int EB = 64;
  localparam logic [1:0] OP_INIT = 2'b00, OP_SQ = 2'b01, OP_MUL = 2'b10, OP_FM = 2'b11;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        start_in = 1'b0;
  logic [0:0]  exp_addr_out;
  logic [31:0] exp_block_in;
  logic        pass_start_out;
  logic [1:0]  pass_op_out;
  logic        pass_done_in;
  logic        busy_out;
  logic        done_out;

  logic        dp_done = 1'b0;
  logic        inj_done = 1'b0;
  logic [63:0] exp_val = 64'd0;

  int n_chk = 0;
  int n_pass = 0;

  assign pass_done_in = dp_done | inj_done;

  modexp_sequencer #(.REGISTER_SIZE(RS), .EXP_BITS(EB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .exp_addr_out(exp_addr_out), .exp_block_in(exp_block_in),
    .pass_start_out(pass_start_out), .pass_op_out(pass_op_out),
    .pass_done_in(pass_done_in), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  // exponent store: one cycle read latency
  always @(posedge clk_in) exp_block_in <= exp_addr_out[0] ? exp_val[63:32] : exp_val[31:0];

  // datapath model and event log, sampled on the falling edge
  int         cyc = 0;
  int         dp_cnt = 0;
  logic [1:0] ops[$];
  int         st_cyc[$];
  int         pd_cyc[$];
  int         addr_log[$];
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         acc_cyc = -1;
  int         busy_low_at_start = 0;
  logic       busy_at_done = 1'b1;
  logic [0:0] last_addr = 1'b0;

  always @(negedge clk_in) begin
    cyc = cyc + 1;
    dp_done = 1'b0;
    if (dp_cnt > 0) begin
      dp_cnt = dp_cnt - 1;
      if (dp_cnt == 0) begin
        dp_done = 1'b1;
        pd_cyc.push_back(cyc);
      end
    end
    if (pass_start_out === 1'b1) begin
      ops.push_back(pass_op_out);
      st_cyc.push_back(cyc);
      dp_cnt = 10;
      if (busy_out !== 1'b1) busy_low_at_start = busy_low_at_start + 1;
    end
    if (done_out === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      busy_at_done = busy_out;
    end
    if (start_in && busy_out === 1'b0 && !rst_in) acc_cyc = cyc;
    if (exp_addr_out !== last_addr) begin
      addr_log.push_back(int'(exp_addr_out));
      last_addr = exp_addr_out;
    end
  end

  task automatic clear_logs();
    ops.delete(); st_cyc.delete(); pd_cyc.delete(); addr_log.delete();
    done_cnt = 0; done_cyc = -1; acc_cyc = -1; busy_low_at_start = 0;
    busy_at_done = 1'b1; last_addr = exp_addr_out;
  endtask

  task automatic do_run(input logic [63:0] e, input int mid_start, output bit timeout);
    clear_logs();
    exp_val = e;
    @(posedge clk_in); #1 start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk_in);
      if (done_cnt > 0) begin timeout = 1'b0; break; end
      if (i == mid_start) begin
        #1 start_in = 1'b1;
        @(posedge clk_in); #1 start_in = 1'b0;
      end
    end
    repeat (5) @(posedge clk_in);
  endtask

  task automatic test_reset();
    #1 rst_in = 1'b1;
    @(posedge clk_in); @(posedge clk_in); #1;
    n_chk++; if (pass_start_out !== 1'b0) $display("FAIL rst_pass_start: got %b want 0", pass_start_out); else n_pass++;
    n_chk++; if (pass_op_out !== 2'b00) $display("FAIL rst_op: got %b want 00", pass_op_out); else n_pass++;
    n_chk++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_out); else n_pass++;
    n_chk++; if (done_out !== 1'b0) $display("FAIL rst_done: got %b want 0", done_out); else n_pass++;
    n_chk++; if (exp_addr_out !== 1'b0) $display("FAIL rst_addr: got %b want 0", exp_addr_out); else n_pass++;
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic test_zero();
    bit to;
    int bad = 0;
    do_run(64'd0, -1, to);
    n_chk++; if (to !== 1'b0) $display("FAIL zero_timeout: no done_out within budget"); else n_pass++;
    n_chk++; if (ops.size() != 66) $display("FAIL zero_count: got %0d want 66", ops.size()); else n_pass++;
    if (ops.size() == 66) begin
      for (int k = 1; k <= 64; k++) if (ops[k] !== OP_SQ) bad++;
      if (ops[0] !== OP_INIT) bad++;
      if (ops[65] !== OP_FM) bad++;
    end else bad = -1;
    n_chk++; if (bad != 0) $display("FAIL zero_ops: got %0d bad opcodes want 0", bad); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_chk++; if (pd_cyc.size() == 0 || done_cyc != pd_cyc[$] + 1)
      $display("FAIL zero_done_lat: got done at %0d want %0d", done_cyc, pd_cyc.size() ? pd_cyc[$] + 1 : -1); else n_pass++;
    n_chk++; if (busy_at_done !== 1'b0) $display("FAIL zero_busy_at_done: got %b want 0", busy_at_done); else n_pass++;
    n_chk++; if (st_cyc.size() == 0 || st_cyc[0] != acc_cyc + 1)
      $display("FAIL zero_first_start: got %0d want %0d", st_cyc.size() ? st_cyc[0] : -1, acc_cyc + 1); else n_pass++;
    n_chk++; if (busy_low_at_start != 0) $display("FAIL zero_busy_pass: got %0d passes with busy low want 0", busy_low_at_start); else n_pass++;
  endtask

  // uses the log of the exponent-0 run: pass k is the SQUARE of bit 64-k
  task automatic test_gaps();
    int other = 0;
    int g1 = -1, g33 = -1;
    if (st_cyc.size() == 66 && pd_cyc.size() == 66) begin
      g1  = st_cyc[1] - pd_cyc[0];
      g33 = st_cyc[33] - pd_cyc[32];
      for (int k = 1; k < 66; k++)
        if (k != 1 && k != 33 && st_cyc[k] - pd_cyc[k-1] != 1) other++;
    end else other = -1;
    n_chk++; if (g1 != 3) $display("FAIL gap_bit63: got %0d want 3", g1); else n_pass++;
    n_chk++; if (g33 != 3) $display("FAIL gap_bit31: got %0d want 3", g33); else n_pass++;
    n_chk++; if (other != 0) $display("FAIL gap_others: got %0d gaps not 1 want 0", other); else n_pass++;
  endtask

  task automatic test_ones();
    bit to;
    int bad = 0;
    int g65 = -1;
    do_run(64'hFFFF_FFFF_FFFF_FFFF, -1, to);
    n_chk++; if (to !== 1'b0) $display("FAIL ones_timeout: no done_out within budget"); else n_pass++;
    n_chk++; if (ops.size() != 130) $display("FAIL ones_count: got %0d want 130", ops.size()); else n_pass++;
    if (ops.size() == 130) begin
      if (ops[0] !== OP_INIT) bad++;
      for (int k = 1; k <= 128; k++) if (ops[k] !== ((k % 2) ? OP_SQ : OP_MUL)) bad++;
      if (ops[129] !== OP_FM) bad++;
      g65 = st_cyc[65] - pd_cyc[64];
    end else bad = -1;
    n_chk++; if (bad != 0) $display("FAIL ones_ops: got %0d bad opcodes want 0", bad); else n_pass++;
    n_chk++; if (g65 != 3) $display("FAIL ones_gap_bit31: got %0d want 3", g65); else n_pass++;
    n_chk++; if (addr_log.size() != 2 || addr_log[0] != 1 || addr_log[1] != 0)
      $display("FAIL ones_addr: got %0d changes first %0d want 1 then 0", addr_log.size(), addr_log.size() ? addr_log[0] : -1); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL ones_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_five();
    bit to;
    int bad = 0;
    logic [1:0] tail [7];
    tail = '{OP_SQ, OP_SQ, OP_MUL, OP_SQ, OP_SQ, OP_MUL, OP_FM};
    do_run(64'h0000_0000_0000_0005, -1, to);
    n_chk++; if (to !== 1'b0) $display("FAIL five_timeout: no done_out within budget"); else n_pass++;
    n_chk++; if (ops.size() != 68) $display("FAIL five_count: got %0d want 68", ops.size()); else n_pass++;
    if (ops.size() == 68) begin
      for (int k = 1; k <= 60; k++) if (ops[k] !== OP_SQ) bad++;
      for (int k = 0; k < 7; k++) if (ops[61 + k] !== tail[k]) bad++;
    end else bad = -1;
    n_chk++; if (bad != 0) $display("FAIL five_ops: got %0d bad opcodes want 0", bad); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL five_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_ignore();
    bit to;
    clear_logs();
    @(posedge clk_in); #1 inj_done = 1'b1;
    @(posedge clk_in); #1 inj_done = 1'b0;
    repeat (5) @(posedge clk_in); #1;
    n_chk++; if (busy_out !== 1'b0) $display("FAIL idle_done_busy: got %b want 0", busy_out); else n_pass++;
    n_chk++; if (ops.size() != 0 || done_cnt != 0)
      $display("FAIL idle_done_effect: got %0d passes %0d dones want 0 0", ops.size(), done_cnt); else n_pass++;
    do_run(64'h0000_0000_0000_0005, 100, to);
    n_chk++; if (to !== 1'b0) $display("FAIL midstart_timeout: no done_out within budget"); else n_pass++;
    n_chk++; if (ops.size() != 68) $display("FAIL midstart_count: got %0d want 68", ops.size()); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL midstart_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_chk++; if (ops.size() == 0 || ops[$] !== OP_FM)
      $display("FAIL midstart_last_op: got %b want 11", ops.size() ? ops[$] : 2'bxx); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    bit reached = 1'b0;
    int n;
    clear_logs();
    exp_val = 64'd0;
    @(posedge clk_in); #1 start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk_in);
      if (ops.size() >= 20) begin reached = 1'b1; break; end
    end
    n_chk++; if (reached !== 1'b1) $display("FAIL rstmid_reach: got %0d passes want 20", ops.size()); else n_pass++;
    repeat (3) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    n_chk++; if (busy_out !== 1'b0 || pass_start_out !== 1'b0 || done_out !== 1'b0)
      $display("FAIL rstmid_ctrl: got busy %b start %b done %b want 0 0 0", busy_out, pass_start_out, done_out); else n_pass++;
    n_chk++; if (pass_op_out !== 2'b00) $display("FAIL rstmid_op: got %b want 00", pass_op_out); else n_pass++;
    n_chk++; if (exp_addr_out !== 1'b0) $display("FAIL rstmid_addr: got %b want 0", exp_addr_out); else n_pass++;
    @(posedge clk_in); #1 rst_in = 1'b0;
    n = ops.size();
    repeat (15) @(posedge clk_in); #1;
    n_chk++; if (ops.size() != n || done_cnt != 0 || busy_out !== 1'b0)
      $display("FAIL rstmid_quiet: got %0d new passes %0d dones busy %b want 0 0 0", ops.size() - n, done_cnt, busy_out); else n_pass++;
    do_run(64'h0000_0000_0000_0005, -1, to);
    n_chk++; if (to !== 1'b0) $display("FAIL rstmid_rerun_timeout: no done_out within budget"); else n_pass++;
    n_chk++; if (ops.size() != 68) $display("FAIL rstmid_rerun_count: got %0d want 68", ops.size()); else n_pass++;
    n_chk++; if (ops.size() != 68 || ops[0] !== OP_INIT || ops[66] !== OP_MUL || ops[67] !== OP_FM)
      $display("FAIL rstmid_rerun_ops: got first %b last %b want 00 11", ops.size() ? ops[0] : 2'bxx, ops.size() ? ops[$] : 2'bxx); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL rstmid_rerun_done: got %0d want 1", done_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_gaps();
    test_ones();
    test_five();
    test_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
